// File: rtl/ahb_reg_slave.sv
// AHB-Lite slave with 16 x 32-bit registers, zero-wait writes and a two-cycle ERROR response.
// Define AHB_REG_SLAVE_RDWAIT_EN to insert one wait state on every legal read.
module ahb_reg_slave #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000,
  parameter int          BASE_CHK  = 1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready_resp,
  output logic        hresp
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
`ifdef AHB_REG_SLAVE_RDWAIT_EN
  localparam logic [2:0] ST_WAIT = 3'd2;
`endif
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]  state_reg, state_next;
  logic [3:0]  idx_reg, idx_next;
  logic        write_reg, write_next;
  logic        accept;
  logic        addr_err;
  logic        wr_en;
  logic        rd_phase;
  logic [31:0] rd_words [16];
  logic        unused_ok;

  // Burst type and the SEQ/NONSEQ distinction carry no meaning for a register file.
  assign unused_ok = ^{hburst, htrans[0]};

  assign accept   = hsel & hready & htrans[1];
  assign addr_err = (hsize != 3'b010) | (haddr[1:0] != 2'b00) |
                    ((BASE_CHK != 0) & (haddr[31:6] != 26'd0));
  assign wr_en    = (state_reg == ST_DATA) & write_reg;

`ifdef AHB_REG_SLAVE_RDWAIT_EN
  logic rd_stall;
  assign rd_stall    = (state_reg == ST_DATA) & ~write_reg;
  assign rd_phase    = (state_reg == ST_WAIT);
  assign hready_resp = (state_reg != ST_ERR1) & ~rd_stall;
`else
  assign rd_phase    = (state_reg == ST_DATA) & ~write_reg;
  assign hready_resp = (state_reg != ST_ERR1);
`endif

  assign hresp  = (state_reg == ST_ERR1) | (state_reg == ST_ERR2);
  assign hrdata = rd_phase ? rd_words[idx_reg] : 32'd0;

  // Every state that completes its data phase this cycle may also take the next address phase.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    write_next = write_reg;
    if (state_reg == ST_ERR1) begin
      state_next = ST_ERR2;
`ifdef AHB_REG_SLAVE_RDWAIT_EN
    end else if (rd_stall) begin
      state_next = ST_WAIT;
`endif
    end else if (accept) begin
      idx_next   = haddr[5:2];
      write_next = hwrite;
      state_next = addr_err ? ST_ERR1 : ST_DATA;
    end else begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_reg <= ST_IDLE;
      idx_reg   <= 4'd0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      write_reg <= write_next;
    end
  end

  // Storage stays in flops so that every word returns to RESET_VAL asynchronously.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_word
      logic [31:0] word_reg;
      always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
          word_reg <= RESET_VAL;
        end else if (wr_en && (idx_reg == 4'(gi))) begin
          word_reg <= hwdata;
        end
      end
      assign rd_words[gi] = word_reg;
    end
  endgenerate

endmodule

// File: tb/tb_ahb_reg_slave.sv
// Randomized bench for ahb_reg_slave against a transaction-level register-file model.
// Acts as both AHB master and interconnect, so it drives hready itself.
module tb_ahb_reg_slave;

  localparam logic [31:0] RST_VAL = 32'ha5a5_5a5a;
  localparam int K_NONE = 0;
  localparam int K_WR   = 1;
  localparam int K_RD   = 2;
  localparam int K_ERR  = 3;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hready;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready_resp;
  logic        hresp;

  always #5 hclk = ~hclk;

  ahb_reg_slave #(.RESET_VAL(RST_VAL), .BASE_CHK(1)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hready(hready), .hwdata(hwdata),
    .hrdata(hrdata), .hready_resp(hready_resp), .hresp(hresp)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          kind;
    logic [31:0] exp;
  } xfer_t;

  xfer_t       q[$];
  xfer_t       ap;
  xfer_t       dp;
  int          step;
  logic        prev_ready;
  logic [31:0] model_mem [16];
  int          chk_cnt = 0;
  int          pass_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic xfer_t idle_xfer();
    xfer_t x;
    x.sel = 1'b0; x.trans = 2'b00; x.addr = 32'd0; x.wr = 1'b0;
    x.size = 3'd2; x.wdata = 32'd0; x.kind = K_NONE; x.exp = 32'd0;
    return x;
  endfunction

  function automatic void push(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                               input logic wr, input logic [2:0] size, input logic [31:0] wdata);
    xfer_t x;
    x = idle_xfer();
    x.sel = sel; x.trans = trans; x.addr = addr; x.wr = wr; x.size = size; x.wdata = wdata;
    q.push_back(x);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = RST_VAL;
  endfunction

  // Transfers are resolved in address order; writes land before any later read sees them.
  function automatic xfer_t next_xfer();
    xfer_t x;
    int    idx;
    if (q.size() == 0) return idle_xfer();
    x = q.pop_front();
    idx = int'(x.addr >> 2) % 16;
    if (x.sel && (x.trans == 2'b10 || x.trans == 2'b11)) begin
      if (x.size != 3'd2 || x.addr % 4 != 0 || x.addr >= 64) begin
        x.kind = K_ERR;
      end else if (x.wr) begin
        x.kind = K_WR;
        model_mem[idx] = x.wdata;
      end else begin
        x.kind = K_RD;
        x.exp = model_mem[idx];
      end
    end
    return x;
  endfunction

  task automatic step_cycle();
    logic        exp_rdy;
    logic        exp_resp;
    logic [31:0] exp_data;
    @(negedge hclk);
    if (prev_ready) begin
      dp = ap;
      step = 0;
      ap = next_xfer();
    end else begin
      step++;
    end
    hsel = ap.sel; htrans = ap.trans; haddr = ap.addr; hwrite = ap.wr; hsize = ap.size;
    hburst = 3'($urandom_range(0, 7));
    hwdata = (dp.kind == K_WR) ? dp.wdata : 32'($urandom);
    exp_rdy = 1'b1; exp_resp = 1'b0; exp_data = 32'd0;
    case (dp.kind)
      K_RD: begin
`ifdef AHB_REG_SLAVE_RDWAIT_EN
        if (step == 0) exp_rdy = 1'b0;
        else exp_data = dp.exp;
`else
        exp_data = dp.exp;
`endif
      end
      K_ERR: begin
        exp_resp = 1'b1;
        if (step == 0) exp_rdy = 1'b0;
      end
      default: ;
    endcase
    hready = exp_rdy;
    #1;
    check($sformatf("hready_resp k%0d s%0d a%h", dp.kind, step, dp.addr), 32'(hready_resp), 32'(exp_rdy));
    check($sformatf("hresp k%0d s%0d a%h", dp.kind, step, dp.addr), 32'(hresp), 32'(exp_resp));
    check($sformatf("hrdata k%0d s%0d a%h", dp.kind, step, dp.addr), hrdata, exp_data);
    prev_ready = exp_rdy;
  endtask

  task automatic run_queue();
    while (q.size() > 0) step_cycle();
    repeat (3) step_cycle();
  endtask

  task automatic push_random();
    int          r;
    logic [31:0] addr;
    logic [2:0]  size;
    r = $urandom_range(0, 9);
    if (r == 0) begin
      push(1'b1, 2'b00, 32'($urandom_range(0, 15) * 4), 1'b1, 3'd2, 32'($urandom));
    end else if (r == 1) begin
      push(1'b1, 2'b01, 32'($urandom_range(0, 15) * 4), 1'b1, 3'd2, 32'($urandom));
    end else if (r == 2) begin
      push(1'b0, 2'b10, 32'($urandom_range(0, 15) * 4), 1'b1, 3'd2, 32'($urandom));
    end else begin
      addr = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3) * 4) : 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 9) == 0) addr = addr + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) addr = addr | (32'd1 << $urandom_range(6, 31));
      size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      push(1'b1, {1'b1, 1'($urandom_range(0, 1))}, addr, 1'($urandom_range(0, 1)), size, 32'($urandom));
    end
  endtask

  initial begin
    hresetn = 1'b0;
    hsel = 1'b0; htrans = 2'b00; haddr = 32'd0; hwrite = 1'b0; hsize = 3'd2;
    hburst = 3'd0; hready = 1'b1; hwdata = 32'd0;
    model_reset();
    dp = idle_xfer(); ap = idle_xfer(); prev_ready = 1'b1; step = 0;
    #2;
    check("reset hready_resp", 32'(hready_resp), 32'd1);
    check("reset hresp", 32'(hresp), 32'd0);
    check("reset hrdata", hrdata, 32'd0);
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;

    // Reset value, write/read, same-word write followed by pipelined read.
    push(1'b1, 2'b10, 32'h00, 1'b0, 3'd2, 32'd0);
    push(1'b1, 2'b10, 32'h04, 1'b1, 3'd2, 32'habcd1234);
    push(1'b1, 2'b10, 32'h04, 1'b0, 3'd2, 32'd0);
    push(1'b1, 2'b10, 32'h00, 1'b1, 3'd2, 32'hcdef9876);
    push(1'b1, 2'b10, 32'h00, 1'b0, 3'd2, 32'd0);
    run_queue();

    // Illegal size, misaligned/out-of-window write, ignored BUSY/unselected, then readback.
    push(1'b1, 2'b10, 32'h08, 1'b0, 3'b001, 32'd0);
    push(1'b1, 2'b10, 32'h41, 1'b1, 3'd2, 32'hdeadbeef);
    push(1'b1, 2'b11, 32'h40, 1'b1, 3'd2, 32'h11111111);
    push(1'b1, 2'b01, 32'h00, 1'b1, 3'd2, 32'h22222222);
    push(1'b0, 2'b10, 32'h00, 1'b1, 3'd2, 32'h33333333);
    push(1'b1, 2'b10, 32'h00, 1'b0, 3'd2, 32'd0);
    push(1'b1, 2'b11, 32'h08, 1'b0, 3'd2, 32'd0);
    push(1'b1, 2'b11, 32'h3c, 1'b0, 3'd2, 32'd0);
    run_queue();

    for (int n = 0; n < 400; n++) push_random();
    run_queue();

    // Reset asserted during ERR1 of a bad write: bus must recover at once, storage cleared.
    push(1'b1, 2'b10, 32'h41, 1'b1, 3'd2, 32'h0badf00d);
    step_cycle();
    step_cycle();
    hresetn = 1'b0;
    hready = 1'b1;
    ap = idle_xfer();
    hsel = 1'b0; htrans = 2'b00;
    #1;
    check("rst_err1 hready_resp", 32'(hready_resp), 32'd1);
    check("rst_err1 hresp", 32'(hresp), 32'd0);
    check("rst_err1 hrdata", hrdata, 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    model_reset();
    dp = idle_xfer(); prev_ready = 1'b1; step = 0;
    for (int i = 0; i < 16; i++) push(1'b1, 2'b10, 32'(i * 4), 1'b0, 3'd2, 32'd0);
    run_queue();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ahb_reg_slave.md
AHB_REG_SLAVE -- requirements
Module: ahb_reg_slave

Interface
REQ-001 The block SHALL have parameter RESET_VAL, default 32'h0000_0000, the reset value of every register word.
REQ-002 The block SHALL have parameter BASE_CHK, default 1, which, when 1, flags haddr[31:6] != 0 as an error.
REQ-003 The block SHALL have port hclk, input, 1 bit: the single clock, rising edge active.
REQ-004 The block SHALL have port hresetn, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port hsel, input, 1 bit: slave select.
REQ-006 The block SHALL have port haddr, input, 32 bits: byte address.
REQ-007 The block SHALL have port htrans, input, 2 bits: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 The block SHALL have port hwrite, input, 1 bit: 1 means write.
REQ-009 The block SHALL have port hsize, input, 3 bits: only 3'b010 (word) is legal.
REQ-010 The block SHALL have port hburst, input, 3 bits: ignored.
REQ-011 The block SHALL have port hready, input, 1 bit: bus-level ready (previous transfer complete).
REQ-012 The block SHALL have port hwdata, input, 32 bits: write data, valid in the data phase.
REQ-013 The block SHALL have port hrdata, output, 32 bits: read data.
REQ-014 The block SHALL have port hready_resp, output, 1 bit: slave ready out.
REQ-015 The block SHALL have port hresp, output, 1 bit: 0=OKAY, 1=ERROR.

Function
REQ-016 The block SHALL accept a transfer at a rising edge when hsel=1, hready=1 and htrans[1]=1; IDLE and BUSY SHALL be answered with zero-wait OKAY and cause no side effect.
REQ-017 At acceptance the block SHALL latch haddr[5:2] (word index), hwrite, and the error flag; the error flag SHALL be 1 when hsize!=3'b010, or haddr[1:0]!=0, or (BASE_CHK=1 and haddr[31:6]!=0).
REQ-018 The storage SHALL be 16 x 32-bit words, with the word index taken from haddr[5:2].
REQ-019 For a legal write, the register SHALL be updated with hwdata at the rising edge ending the data phase (hready_resp=1); a write SHALL take zero wait states.
REQ-020 For a legal read without wait states, hrdata SHALL be the addressed word during the data phase, with hready_resp=1 and hresp=0.
REQ-021 A read whose address phase overlaps the data phase of a write to the same word SHALL return the newly written value.
REQ-022 The FSM SHALL have states IDLE, DATA, WAIT, ERR1 and ERR2.
REQ-023 The FSM SHALL transition IDLE->DATA on an accepted legal transfer, IDLE->ERR1 on an accepted illegal transfer, DATA->WAIT on a read when waits are enabled, DATA/WAIT->IDLE or a new phase on the next acceptance, ERR1->ERR2 unconditionally, and ERR2->IDLE or a new phase.
REQ-024 The error response SHALL take two cycles: ERR1 drives hready_resp=0 and hresp=1; ERR2 drives hready_resp=1 and hresp=1.
REQ-025 An erroneous write SHALL not modify storage, and an erroneous read SHALL drive hrdata=0.
REQ-026 The block SHALL accept pipelined back-to-back transfers every cycle while hready_resp=1.
REQ-027 hrdata SHALL be 0 whenever it is not in a read data phase.
REQ-028 When hsel=0 during an address phase, the block SHALL leave state unchanged and drive hready_resp=1 and hresp=0.

Reset
REQ-029 While hresetn=0, the block SHALL hold the FSM in IDLE, all 16 words at RESET_VAL, hrdata=0, hready_resp=1, hresp=0 and the latched phase cleared, asynchronously.
REQ-030 Reset asserted mid-transfer (including ERR1 or WAIT) SHALL abort the transfer and commit no write; after release, the first transfer SHALL be accepted on the first qualifying edge.

Configuration
REQ-031 With macro AHB_REG_SLAVE_RDWAIT_EN defined, every legal read SHALL insert exactly one wait state: the first data-phase cycle drives hready_resp=0, and the second drives hready_resp=1 with valid hrdata.
REQ-032 With AHB_REG_SLAVE_RDWAIT_EN undefined, the WAIT state SHALL be absent and reads SHALL be zero-wait; writes and errors SHALL be identical in both builds.

Verification
REQ-033 Reset release followed by a read of addr 0x00 -> hrdata=RESET_VAL, hresp=0, zero wait (RDWAIT off).
REQ-034 Write 0x04=32'habcd1234, then read 0x04 -> hrdata=32'habcd1234, hresp=0.
REQ-035 Write 0x00=32'hcdef9876 with a pipelined NONSEQ read of 0x00 in the data phase -> read returns 32'hcdef9876.
REQ-036 Read with hsize=3'b001 at 0x08, and write at 0x41 -> each gives ERR1 (hready_resp=0, hresp=1) then ERR2 (hready_resp=1, hresp=1), with storage unchanged.
REQ-037 RDWAIT build, read of 0x04 after the write of 32'habcd1234 -> one cycle hready_resp=0, then hready_resp=1 with hrdata=32'habcd1234.
REQ-038 hresetn pulsed low during the ERR1 of an erroneous write -> hready_resp=1 and hresp=0 immediately, and all words read back as RESET_VAL.
